axis_frame_framer: RTL
======================

# axis_frame_framer

Frames the headerless 64-bit pixel stream leaving the DVP capture block into AXI4-Stream video packets with `tuser` start-of-frame and `tlast` end-of-line, so a VDMA S2MM channel can consume them. It sits directly downstream of the DVP capture stream output in the AXI clock domain. Line and frame geometry come from configuration inputs. A frame-start pulse, which is the vsync already synchronised into the AXI domain, realigns it to the frame.

## Interface
- `P_AXIS_DATA_WIDTH`, 64, tdata width in bits.
- `P_CNT_WIDTH`, 16, width of geometry inputs and counters.
- `i_axi_clk`  in  1  the single clock.
- `i_axi_rstn`  in  1  reset; synchronous, active-low.
- `i_ena`  in  1  framing enable (level).
- `i_sof`  in  1  frame-start pulse, one cycle, AXI domain.
- `i_beats_per_line`  in  P_CNT_WIDTH  beats per line.
- `i_lines_per_frame`  in  P_CNT_WIDTH  lines per frame.
- `i_err_clr`  in  1  clears the sticky error flags.
- `s_axis_tvalid`  in  1  input stream valid.
- `s_axis_tready`  out  1  input stream ready.
- `s_axis_tdata`  in  P_AXIS_DATA_WIDTH  input stream data.
- `m_axis_tvalid`  out  1  output stream valid.
- `m_axis_tready`  in  1  output stream ready.
- `m_axis_tdata`  out  P_AXIS_DATA_WIDTH  output stream data.
- `m_axis_tlast`  out  1  marks the last beat of a line.
- `m_axis_tuser`  out  1  marks the first beat of a frame.
- `o_frame_cnt`  out  P_CNT_WIDTH  completed frames; wraps.
- `o_err_short`  out  1  sticky flag: `i_sof` arrived mid-frame.
- `o_err_long`  out  1  sticky flag: beats arrived while not in a frame.

## Operation
- States: `IDLE` and `ACTIVE`.
- **IDLE**
  - `s_axis_tready`=1; accepted beats are dropped.
  - A dropped beat sets `o_err_long` only if `i_ena`=1 and at least one frame has completed since enable.
- **IDLE → ACTIVE**: when `i_ena`=1, `i_sof`=1 and both geometry inputs are nonzero.
  - Geometry is latched into `bpl_q`/`lpf_q` on that cycle.
  - A beat accepted in the same cycle is beat 0 of the frame.
  - A zero geometry value keeps the block in `IDLE` and ignores the `i_sof`.
- **ACTIVE**
  - Each accepted beat is forwarded.
  - `tuser`=1 when col==0 and row==0.
  - `tlast`=1 when col==bpl_q-1.
  - col increments and wraps to 0 at bpl_q-1; row increments on wrap.
- **Frame end**: the beat with col==bpl_q-1 and row==lpf_q-1 increments `o_frame_cnt` and returns to `IDLE`.
- **Mid-frame `i_sof`** (ACTIVE, not at col=row=0):
  - Sets `o_err_short`.
  - Re-latches geometry and resets col and row.
  - A beat accepted in the same cycle becomes beat 0 of the new frame, with `tuser`=1.
  - The truncated frame does not count.
- **`i_sof` at col=row=0 in ACTIVE**: harmless; no error.
- **`i_ena` falls**: next state is `IDLE`, counters clear, no error is set. Beats already in the output register still drain.
- **Error flags**: `i_err_clr` clears them. A set event in the same cycle as a clear wins.
- **Counters**: all arithmetic is unsigned at P_CNT_WIDTH; `o_frame_cnt` wraps from 0xFFFF to 0.

## Timing
- Output is driven through a 2-entry skid buffer.
  - Latency is 1 cycle from input acceptance to `m_axis_tvalid`.
  - Full throughput: 1 beat per cycle while `m_axis_tready`=1.
- `s_axis_tready` depends only on registered skid-buffer state; there is no combinational path from `m_axis_tready`.
  - In `IDLE`, `s_axis_tready` is forced to 1 (drop path).
- `m_axis_tdata`/`tlast`/`tuser` are held stable while `tvalid`=1 and `tready`=0.
- Reset values:
  - `m_axis_tvalid`=0, `tlast`=0, `tuser`=0, `tdata`=0.
  - `s_axis_tready`=0 during reset, 1 from the first cycle after reset.
  - `o_frame_cnt`=0, both error flags 0, state `IDLE`.
- Reset mid-frame discards the skid-buffer contents; no partial `tlast` is emitted.

## Structure
- Package `dvp_pkg`:
  - `typedef enum logic {IDLE, ACTIVE} framer_state_t`.
  - `DVP_CNT_WIDTH`=16.
  - `AXIS_DATA_WIDTH`=64.
- Sub-module `axis_skid_buf`: 2-entry register slice, parameterised on payload width. The payload is {tuser, tlast, tdata}.
- The top level holds the FSM, the col/row/frame counters and the error logic.

## Test plan
- **Nominal**: bpl=4, lpf=3, `i_sof` then 12 beats with `m_axis_tready`=1 → `tuser` on beat 0, `tlast` on beats 3, 7 and 11, `o_frame_cnt`=1, errors 0.
- **Backpressure**: same frame, `m_axis_tready` toggled at random at 50% → identical output sequence, no beat lost or duplicated, data stable while stalled.
- **Short frame**: `i_sof` after 6 beats of a 12-beat frame → `o_err_short`=1, next beat carries `tuser`, `o_frame_cnt` unchanged until the new 12 beats finish, then reads 1.
- **Long frame**: 14 beats after a 12-beat frame with no new `i_sof` → 2 beats dropped, `o_err_long`=1; `i_err_clr` → flag reads 0.
- **Disable/zero geometry**: `i_ena`=0 or bpl=0 with `i_sof` → all input accepted and dropped, `m_axis_tvalid` stays 0, no error.
- **Reset and wrap**: reset asserted mid-line → all outputs at their reset values next cycle. Force `o_frame_cnt` to 0xFFFF, complete one frame → count reads 0.

Source files
------------

// File: rtl/dvp_pkg.sv
// dvp_pkg: types and width constants used by the DVP-to-AXI4-Stream framing path.
//   framer_state_t  : framer FSM state encoding
//   DVP_CNT_WIDTH   : width of geometry inputs and line/frame counters
//   AXIS_DATA_WIDTH : pixel stream tdata width
package dvp_pkg;

   localparam int DVP_CNT_WIDTH   = 16;
   localparam int AXIS_DATA_WIDTH = 64;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } framer_state_t;

endpackage

// File: rtl/axis_skid_buf.sv
// axis_skid_buf: 2-entry AXI4-Stream register slice.
// Ports:
//   clk, rstn          : clock, synchronous active-low reset
//   s_valid/s_ready/s_data : upstream side; s_ready comes straight from a flop
//   m_valid/m_ready/m_data : downstream side; fully registered
// A beat accepted on one edge is visible on m_* after that edge (1-cycle
// latency). The second entry absorbs the beat that arrives while the output
// entry is stalled, so s_ready never needs to look at m_ready.
module axis_skid_buf #(
   parameter int P_WIDTH = 66
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               s_valid,
   output logic               s_ready,
   input  logic [P_WIDTH-1:0] s_data,
   output logic               m_valid,
   input  logic               m_ready,
   output logic [P_WIDTH-1:0] m_data
);

   logic               main_valid_r;
   logic [P_WIDTH-1:0] main_data_r;
   logic               skid_valid_r;
   logic [P_WIDTH-1:0] skid_data_r;
   logic               ready_r;

   logic               s_fire_s;
   logic               m_fire_s;
   logic               main_valid_nx_s;
   logic [P_WIDTH-1:0] main_data_nx_s;
   logic               skid_valid_nx_s;
   logic [P_WIDTH-1:0] skid_data_nx_s;

   // Next-state of the two entries: output entry refills from skid first, then from input.
   always_comb begin
      s_fire_s        = s_valid & ready_r;
      m_fire_s        = main_valid_r & m_ready;
      main_valid_nx_s = main_valid_r;
      main_data_nx_s  = main_data_r;
      skid_valid_nx_s = skid_valid_r;
      skid_data_nx_s  = skid_data_r;
      if (!main_valid_r || m_fire_s) begin
         if (skid_valid_r) begin
            // ready_r was low, so no new beat can arrive this cycle
            main_valid_nx_s = 1'b1;
            main_data_nx_s  = skid_data_r;
            skid_valid_nx_s = 1'b0;
         end else if (s_fire_s) begin
            main_valid_nx_s = 1'b1;
            main_data_nx_s  = s_data;
         end else begin
            main_valid_nx_s = 1'b0;
         end
      end else begin
         if (s_fire_s) begin
            skid_valid_nx_s = 1'b1;
            skid_data_nx_s  = s_data;
         end else begin
            skid_valid_nx_s = skid_valid_r;
         end
      end
   end

   // Entry registers; ready is precomputed from the next skid state so it is a pure flop.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         main_valid_r <= 1'b0;
         main_data_r  <= {P_WIDTH{1'b0}};
         skid_valid_r <= 1'b0;
         skid_data_r  <= {P_WIDTH{1'b0}};
         ready_r      <= 1'b0;
      end else begin
         main_valid_r <= main_valid_nx_s;
         main_data_r  <= main_data_nx_s;
         skid_valid_r <= skid_valid_nx_s;
         skid_data_r  <= skid_data_nx_s;
         ready_r      <= !skid_valid_nx_s;
      end
   end

   assign s_ready = ready_r;
   assign m_valid = main_valid_r;
   assign m_data  = main_data_r;

endmodule

// File: rtl/axis_frame_framer.sv
// axis_frame_framer: frames a headerless pixel stream into AXI4-Stream video
// packets (tuser = start of frame, tlast = end of line) for a VDMA S2MM port.
// Ports:
//   i_axi_clk, i_axi_rstn          : clock, synchronous active-low reset
//   i_ena, i_sof                   : framing enable, synchronised vsync pulse
//   i_beats_per_line, i_lines_per_frame : frame geometry, latched at frame start
//   i_err_clr                      : clears sticky error flags
//   s_axis_*                       : input pixel stream (no tlast/tuser)
//   m_axis_*                       : framed output stream via 2-entry skid buffer
//   o_frame_cnt                    : completed frames, wraps
//   o_err_short / o_err_long       : sticky: sof mid-frame / beats outside a frame
module axis_frame_framer
   import dvp_pkg::*;
#(
   parameter int P_AXIS_DATA_WIDTH = AXIS_DATA_WIDTH,
   parameter int P_CNT_WIDTH       = DVP_CNT_WIDTH
) (
   input  logic                         i_axi_clk,
   input  logic                         i_axi_rstn,
   input  logic                         i_ena,
   input  logic                         i_sof,
   input  logic [P_CNT_WIDTH-1:0]       i_beats_per_line,
   input  logic [P_CNT_WIDTH-1:0]       i_lines_per_frame,
   input  logic                         i_err_clr,
   input  logic                         s_axis_tvalid,
   output logic                         s_axis_tready,
   input  logic [P_AXIS_DATA_WIDTH-1:0] s_axis_tdata,
   output logic                         m_axis_tvalid,
   input  logic                         m_axis_tready,
   output logic [P_AXIS_DATA_WIDTH-1:0] m_axis_tdata,
   output logic                         m_axis_tlast,
   output logic                         m_axis_tuser,
   output logic [P_CNT_WIDTH-1:0]       o_frame_cnt,
   output logic                         o_err_short,
   output logic                         o_err_long
);

   localparam logic [P_CNT_WIDTH-1:0] CNT_ZERO = {P_CNT_WIDTH{1'b0}};
   localparam logic [P_CNT_WIDTH-1:0] CNT_ONE  = {{(P_CNT_WIDTH-1){1'b0}}, 1'b1};

   framer_state_t              state_r, state_nx_s;
   logic [P_CNT_WIDTH-1:0]     col_r, col_nx_s;
   logic [P_CNT_WIDTH-1:0]     row_r, row_nx_s;
   logic [P_CNT_WIDTH-1:0]     bpl_r, bpl_nx_s;
   logic [P_CNT_WIDTH-1:0]     lpf_r, lpf_nx_s;
   logic [P_CNT_WIDTH-1:0]     frame_cnt_r;
   logic                       err_short_r;
   logic                       err_long_r;
   logic                       done_r, done_nx_s;   // a frame completed since enable
   logic                       idle_ready_r;        // low only while in reset

   // Position/geometry that applies to the beat accepted this cycle
   logic [P_CNT_WIDTH-1:0]     beat_col_s, beat_row_s, beat_bpl_s, beat_lpf_s;
   logic                       take_s;
   logic                       tuser_s, tlast_s, frame_end_s;
   logic                       set_short_s, set_long_s;
   logic                       s_fire_s, geom_ok_s, at_origin_s;
   logic                       buf_ready_s;
   logic [P_AXIS_DATA_WIDTH+1:0] buf_out_s;

   assign s_fire_s    = s_axis_tvalid & s_axis_tready;
   assign geom_ok_s   = (i_beats_per_line != CNT_ZERO) && (i_lines_per_frame != CNT_ZERO);
   assign at_origin_s = (col_r == CNT_ZERO) && (row_r == CNT_ZERO);

   // IDLE always accepts (drop path); ACTIVE is gated by the skid buffer's registered ready.
   assign s_axis_tready = (state_r == IDLE) ? idle_ready_r : buf_ready_s;

   // FSM next state, beat context selection, counter advance and error events.
   always_comb begin
      state_nx_s  = state_r;
      col_nx_s    = col_r;
      row_nx_s    = row_r;
      bpl_nx_s    = bpl_r;
      lpf_nx_s    = lpf_r;
      done_nx_s   = done_r;
      beat_col_s  = col_r;
      beat_row_s  = row_r;
      beat_bpl_s  = bpl_r;
      beat_lpf_s  = lpf_r;
      take_s      = 1'b0;
      tuser_s     = 1'b0;
      tlast_s     = 1'b0;
      frame_end_s = 1'b0;
      set_short_s = 1'b0;
      set_long_s  = 1'b0;

      case (state_r)
         IDLE: begin
            if (i_ena && i_sof && geom_ok_s) begin
               state_nx_s = ACTIVE;
               bpl_nx_s   = i_beats_per_line;
               lpf_nx_s   = i_lines_per_frame;
               col_nx_s   = CNT_ZERO;
               row_nx_s   = CNT_ZERO;
               beat_col_s = CNT_ZERO;
               beat_row_s = CNT_ZERO;
               beat_bpl_s = i_beats_per_line;
               beat_lpf_s = i_lines_per_frame;
               // IDLE ready ignores the buffer; if the previous frame's tail still
               // fills both entries, this beat cannot be stored and beat 0 is the next one.
               take_s     = s_fire_s & buf_ready_s;
            end else begin
               set_long_s = s_fire_s & i_ena & done_r;
            end
            if (!i_ena) begin
               done_nx_s = 1'b0;
            end else begin
               done_nx_s = done_r;
            end
         end
         ACTIVE: begin
            if (!i_ena) begin
               state_nx_s = IDLE;
               col_nx_s   = CNT_ZERO;
               row_nx_s   = CNT_ZERO;
               done_nx_s  = 1'b0;
            end else if (i_sof && !at_origin_s) begin
               set_short_s = 1'b1;
               col_nx_s    = CNT_ZERO;
               row_nx_s    = CNT_ZERO;
               if (geom_ok_s) begin
                  bpl_nx_s   = i_beats_per_line;
                  lpf_nx_s   = i_lines_per_frame;
                  beat_col_s = CNT_ZERO;
                  beat_row_s = CNT_ZERO;
                  beat_bpl_s = i_beats_per_line;
                  beat_lpf_s = i_lines_per_frame;
                  take_s     = s_fire_s;
               end else begin
                  // restart requested with unusable geometry: abandon framing
                  state_nx_s = IDLE;
               end
            end else begin
               take_s = s_fire_s;
            end
         end
         default: begin
            state_nx_s = IDLE;
            col_nx_s   = CNT_ZERO;
            row_nx_s   = CNT_ZERO;
         end
      endcase

      if (take_s) begin
         tuser_s = (beat_col_s == CNT_ZERO) && (beat_row_s == CNT_ZERO);
         tlast_s = (beat_col_s == (beat_bpl_s - CNT_ONE));
         if (tlast_s) begin
            col_nx_s = CNT_ZERO;
            if (beat_row_s == (beat_lpf_s - CNT_ONE)) begin
               frame_end_s = 1'b1;
               row_nx_s    = CNT_ZERO;
               state_nx_s  = IDLE;
               done_nx_s   = 1'b1;
            end else begin
               row_nx_s = beat_row_s + CNT_ONE;
            end
         end else begin
            col_nx_s = beat_col_s + CNT_ONE;
         end
      end else begin
         tuser_s = 1'b0;
         tlast_s = 1'b0;
      end
   end

   // State, counters, geometry and sticky flags; a set event beats a same-cycle clear.
   always_ff @(posedge i_axi_clk) begin
      if (!i_axi_rstn) begin
         state_r      <= IDLE;
         col_r        <= CNT_ZERO;
         row_r        <= CNT_ZERO;
         bpl_r        <= CNT_ZERO;
         lpf_r        <= CNT_ZERO;
         frame_cnt_r  <= CNT_ZERO;
         err_short_r  <= 1'b0;
         err_long_r   <= 1'b0;
         done_r       <= 1'b0;
         idle_ready_r <= 1'b0;
      end else begin
         state_r      <= state_nx_s;
         col_r        <= col_nx_s;
         row_r        <= row_nx_s;
         bpl_r        <= bpl_nx_s;
         lpf_r        <= lpf_nx_s;
         done_r       <= done_nx_s;
         idle_ready_r <= 1'b1;
         if (frame_end_s) begin
            frame_cnt_r <= frame_cnt_r + CNT_ONE;
         end
         if (set_short_s) begin
            err_short_r <= 1'b1;
         end else if (i_err_clr) begin
            err_short_r <= 1'b0;
         end
         if (set_long_s) begin
            err_long_r <= 1'b1;
         end else if (i_err_clr) begin
            err_long_r <= 1'b0;
         end
      end
   end

   axis_skid_buf #(
      .P_WIDTH (P_AXIS_DATA_WIDTH + 2)
   ) u_skid (
      .clk     (i_axi_clk),
      .rstn    (i_axi_rstn),
      .s_valid (take_s),
      .s_ready (buf_ready_s),
      .s_data  ({tuser_s, tlast_s, s_axis_tdata}),
      .m_valid (m_axis_tvalid),
      .m_ready (m_axis_tready),
      .m_data  (buf_out_s)
   );

   assign m_axis_tuser = buf_out_s[P_AXIS_DATA_WIDTH+1];
   assign m_axis_tlast = buf_out_s[P_AXIS_DATA_WIDTH];
   assign m_axis_tdata = buf_out_s[P_AXIS_DATA_WIDTH-1:0];
   assign o_frame_cnt  = frame_cnt_r;
   assign o_err_short  = err_short_r;
   assign o_err_long   = err_long_r;

endmodule
